// File: rtl/coeff_loader.sv
// Byte-stream command decoder: SETADDR (01 A1 A0) and WRITE (02 D4..D0) commands
// drive a 36-bit coefficient memory write port with an auto-incrementing address.
module coeff_loader #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    output logic [8:0]  addressW,
    output logic [35:0] datain,
    output logic        we,
    output logic        busy,
    output logic        cmd_err,
    output logic [9:0]  wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [35:0]  asm_q, asm_d;
    logic         a1_q, a1_d;
    logic [8:0]   ptr_q, ptr_d;
    logic [35:0]  datain_q, datain_d;
    logic         we_q, we_d;
    logic         err_q, err_d;
    logic [9:0]   wrc_q, wrc_d;
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            asm_q    <= '0;
            a1_q     <= 1'b0;
            ptr_q    <= '0;
            datain_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wrc_q    <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            a1_q     <= a1_d;
            ptr_q    <= ptr_d;
            datain_q <= datain_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wrc_q    <= wrc_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        a1_d     = a1_q;
        ptr_d    = ptr_q;
        datain_d = datain_q;
        we_d     = 1'b0;
        err_d    = 1'b0;
        wrc_d    = wrc_q;
        to_d     = to_q;

        // Post-write bookkeeping happens on the cycle the we pulse is visible.
        if (we_q) begin
            ptr_d = ptr_q + 9'd1;
            if (wrc_q != 10'd1023) begin
                wrc_d = wrc_q + 10'd1;
            end
        end

        case (state_q)
            IDLE: begin
                to_d  = '0;
                cnt_d = '0;
                if (rxready) begin
                    if (rxdata == 8'h01) begin
                        state_d = ADDR;
                    end else if (rxdata == 8'h02) begin
                        state_d = DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR, DATA: begin
                if (rxready) begin
                    to_d = '0;
                    if (state_q == ADDR) begin
                        if (cnt_q == 3'd0) begin
                            a1_d  = rxdata[0];
                            cnt_d = 3'd1;
                        end else begin
                            ptr_d   = {a1_q, rxdata};
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        // Five shifts leave exactly {D4[3:0],D3,D2,D1,D0} in 36 bits.
                        asm_d = {asm_q[27:0], rxdata};
                        if (cnt_q == 3'd4) begin
                            we_d     = 1'b1;
                            datain_d = asm_d;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    to_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                to_d    = '0;
            end
        endcase
    end

    assign addressW = ptr_q;
    assign datain   = datain_q;
    assign we       = we_q;
    assign busy     = (state_q != IDLE);
    assign cmd_err  = err_q;
    assign wr_count = wrc_q;

endmodule
